// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared ISA definitions for the single-cycle core front end:
//   - default fetch geometry (PC width, instruction width, jump-LUT depth)
//   - 4-bit opcode constants
//   - fetch state enumeration
//   - branch_taken(): resolves a conditional jump from opcode and flags
// -----------------------------------------------------------------------------
package isa_pkg;

    localparam int PCW_DEF  = 10;
    localparam int IW_DEF   = 9;
    localparam int LUTD_DEF = 32;

    localparam logic [3:0] OP_JMP  = 4'b0000;
    localparam logic [3:0] OP_BEQ  = 4'b0001;
    localparam logic [3:0] OP_BNE  = 4'b0010;
    localparam logic [3:0] OP_BLT  = 4'b0011;
    localparam logic [3:0] OP_BGE  = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } fetch_state_e;

    // Conditional-jump resolution; opcodes that are not conditional jumps
    // never take, so a stray jtype cannot redirect the PC.
    function automatic logic branch_taken(input logic [3:0] op,
                                          input logic       z,
                                          input logic       n);
        logic t;
        case (op)
            OP_BEQ:  t = z;
            OP_BNE:  t = ~z;
            OP_BLT:  t = n;
            OP_BGE:  t = ~n;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/jump_lut.sv
// -----------------------------------------------------------------------------
// jump_lut
// Jump-target lookup table: DEPTH entries of DW bits, synchronous write,
// combinational read. Contents are deliberately not reset.
// Ports:
//   clk    in  rising-edge clock
//   we     in  write strobe (already qualified by the caller)
//   waddr  in  write index
//   wdata  in  write data (jump target)
//   raddr  in  read index
//   rdata  out read data, combinational
// -----------------------------------------------------------------------------
module jump_lut #(
    parameter int DW    = 10,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Table write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read port
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the single-cycle core. Owns the PC, addresses
// instruction memory, forwards the fetched word to the decoder, and chooses
// the next PC (PC+1 or a jump-LUT target) from the decoder strobes and the
// registered Z/N flags. A start/done handshake frames each program run.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   start                   begins a program at PC 0 (IDLE/DONE only)
//   done, running           state indicators (DONE / RUN)
//   imem_addr, imem_data    instruction memory address / combinational data
//   instr, pc               instruction to decoder (0 outside RUN), current PC
//   uncd_jmp, jtype         decoder jump strobes
//   flag_we, z_in, n_in     compare flag update
//   lut_we, lut_addr,
//   lut_wdata               jump-LUT write port (ignored during RUN)
// -----------------------------------------------------------------------------
module fetch_unit
    import isa_pkg::*;
#(
    parameter int         PCW     = PCW_DEF,
    parameter int         IW      = IW_DEF,
    parameter int         LUTD    = LUTD_DEF,
    parameter logic [3:0] HALT_OP = OP_HALT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    done,
    output logic                    running,
    output logic [PCW-1:0]          imem_addr,
    input  logic [IW-1:0]           imem_data,
    output logic [IW-1:0]           instr,
    output logic [PCW-1:0]          pc,
    input  logic                    uncd_jmp,
    input  logic                    jtype,
    input  logic                    flag_we,
    input  logic                    z_in,
    input  logic                    n_in,
    input  logic                    lut_we,
    input  logic [$clog2(LUTD)-1:0] lut_addr,
    input  logic [PCW-1:0]          lut_wdata
);

    localparam int LUT_AW = $clog2(LUTD);

    fetch_state_e   state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic           z_q, z_d;
    logic           n_q, n_d;

    logic [3:0]        opcode_s;
    logic [LUT_AW-1:0] lut_idx_s;
    logic [PCW-1:0]    lut_target_s;
    logic              is_run_s;
    logic              halt_s;
    logic              taken_s;
    logic              pc_at_max_s;
    logic              lut_wen_s;

    assign opcode_s    = imem_data[IW-1 -: 4];
    assign lut_idx_s   = imem_data[LUT_AW-1:0];
    assign is_run_s    = (state_q == ST_RUN);
    assign halt_s      = (opcode_s == HALT_OP);
    assign pc_at_max_s = (pc_q == {PCW{1'b1}});
    // The table may only be reprogrammed while no program is executing.
    assign lut_wen_s   = lut_we & ~is_run_s;

    jump_lut #(
        .DW    (PCW),
        .DEPTH (LUTD),
        .AW    (LUT_AW)
    ) u_jump_lut (
        .clk   (clk),
        .we    (lut_wen_s),
        .waddr (lut_addr),
        .wdata (lut_wdata),
        .raddr (lut_idx_s),
        .rdata (lut_target_s)
    );

    // Jump resolution against the registered flags (same-cycle flag writes
    // only affect later instructions).
    always_comb begin
        taken_s = 1'b0;
        if (uncd_jmp) begin
            taken_s = 1'b1;
        end else if (jtype) begin
            taken_s = branch_taken(opcode_s, z_q, n_q);
        end else begin
            taken_s = 1'b0;
        end
    end

    // State, PC and flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= {PCW{1'b0}};
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                // Falling off the end of memory finishes the program unless
                // the last word redirects the PC.
                if (halt_s || (pc_at_max_s && !taken_s)) state_d = ST_DONE;
                else                                      state_d = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next-PC and flag-update logic
    always_comb begin
        pc_d = pc_q;
        z_d  = z_q;
        n_d  = n_q;
        case (state_q)
            ST_RUN: begin
                if (halt_s) begin
                    pc_d = pc_q;
                end else if (taken_s) begin
                    pc_d = lut_target_s;
                end else if (pc_at_max_s) begin
                    pc_d = pc_q;  // hold at the top address, no wrap
                end else begin
                    pc_d = pc_q + {{(PCW-1){1'b0}}, 1'b1};
                end
                if (flag_we) begin
                    z_d = z_in;
                    n_d = n_in;
                end else begin
                    z_d = z_q;
                    n_d = n_q;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pc_d = {PCW{1'b0}};
                    z_d  = 1'b0;
                    n_d  = 1'b0;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                pc_d = {PCW{1'b0}};
                z_d  = 1'b0;
                n_d  = 1'b0;
            end
        endcase
    end

    // Output logic; outside RUN the decoder sees an all-zero word.
    always_comb begin
        running   = is_run_s;
        done      = (state_q == ST_DONE);
        pc        = pc_q;
        imem_addr = pc_q;
        if (is_run_s) instr = imem_data;
        else          instr = {IW{1'b0}};
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle core. It owns the PC, drives the instruction-memory address, and presents the fetched 9-bit instruction to the control decoder and register file.
- It consumes the decoder's uncd_jmp / jtype strobes and the compare flags to pick the next PC. The next PC is PC+1 or a jump target held in an internal 32-entry jump lookup table.
- It runs a start/done program handshake with the testbench/top level.

Parameters:
- PCW, 10, PC / instruction-memory address width
- IW, 9, instruction width; opcode = instr[IW-1:IW-4], jump-LUT index = instr[4:0]
- LUTD, 32, jump LUT depth (index width 5)
- HALT_OP, 4'b1001, opcode that ends the program

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse in IDLE/DONE begins a program at PC 0
- done  out  1  high in DONE until next start
- running  out  1  high in RUN
- imem_addr  out  PCW  instruction-memory address (= pc)
- imem_data  in  IW  instruction word, combinational read of imem_addr
- instr  out  IW  instruction to decoder; forced to 0 (NOP-safe) outside RUN
- pc  out  PCW  current PC
- uncd_jmp  in  1  from decoder: unconditional jump
- jtype  in  1  from decoder: any jump
- flag_we  in  1  cmp executing; latch flags this cycle
- z_in  in  1  ALU zero flag
- n_in  in  1  ALU negative flag
- lut_we  in  1  jump-LUT write strobe; honoured only when not RUN
- lut_addr  in  5  jump-LUT write index
- lut_wdata  in  PCW  jump-LUT write target

Behaviour:
Reset (reset_n=0, async, takes effect immediately):
- state=IDLE, pc=0, Z=N=0, done=0, running=0.
- LUT contents are not reset.

State machine:
- IDLE: start=1 -> RUN, pc=0. Otherwise hold.
- RUN: each clock commits one instruction. Leave to DONE when opcode==HALT_OP, or when pc==2^PCW-1 and the instruction is not a taken jump. pc holds in DONE.
- DONE: done=1. start=1 -> RUN, pc=0, done drops the same edge.
- start is ignored while in RUN.

Next PC in RUN:
- uncd_jmp=1: pc <= LUT[instr[4:0]].
- jtype=1 with uncd_jmp=0: conditional on opcode.
  - 0001 taken if Z
  - 0010 taken if !Z
  - 0011 taken if N
  - 0100 taken if !N
  - Any other opcode with jtype=1: not taken.
  - Taken: pc <= LUT[idx]. Not taken: pc <= pc+1.
- Otherwise pc <= pc+1.
- Flags used are the registered Z/N; flags written this cycle affect only later instructions.

Flags:
- flag_we=1 in RUN: Z<=z_in, N<=n_in at the edge. Otherwise hold.
- Flags clear on reset and on start.

Jump LUT:
- Synchronous write when lut_we=1 and state!=RUN.
- lut_we during RUN is dropped.
- Read is combinational.

Timing and outputs:
- Latency: instr valid combinationally the same cycle pc is set.
- Branch penalty: 0 cycles.
- running = (state==RUN). done = (state==DONE).
- HALT instruction: pc does not advance. instr reads 0 from the next cycle.
- Reset asserted mid-RUN: immediate IDLE, pc=0, no further commits.

Decomposition:
- Shared package (isa_pkg): opcode constants and the fetch state enum.
  - Opcodes: OP_JMP=0000, OP_BEQ=0001, OP_BNE=0010, OP_BLT=0011, OP_BGE=0100, OP_HALT=1001.
  - State enum: IDLE/RUN/DONE.
- One sub-module, jump_lut: 32xPCW register array, sync write, async read.

Test Plan:
- Reset then start, imem returns ADD (0101_00000) at pc 0..3 and HALT at 4 -> pc steps 0,1,2,3,4; done=1 next cycle; pc holds 4; instr=0.
- LUT[3]=0x020 written in IDLE; program JMP idx3 at pc 0 (uncd_jmp=jtype=1) -> pc=0x020 the next cycle.
- cmp at pc 0 with flag_we=1, z_in=1; BEQ idx3 at pc 1 -> pc 1 -> 0x020. Repeat with z_in=0 -> pc 2. BNE with z_in=0 -> 0x020.
- BLT with N=1 -> taken. BGE with N=1 -> pc+1. Same-cycle flag_we alongside a branch uses the old flags.
- lut_we during RUN with LUT[3]=0x020, write 0x055 -> LUT[3] still 0x020 after DONE.
- reset_n low mid-RUN at pc 7 -> pc=0, running=0 asynchronously. Second start after DONE restarts at pc 0 with Z=N=0.
